// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster timing constants, buffer base addresses and decode helpers
package video_timing_pkg;

    localparam int ADDR_W = 21;
    typedef logic [ADDR_W-1:0] word_addr_t;

    // Raster geometry in clk8 cycles and lines
    localparam int H_TOTAL_DEF   = 352;
    localparam int V_TOTAL_DEF   = 370;
    localparam int H_VISIBLE_DEF = 256;
    localparam int V_VISIBLE_DEF = 342;

    // Sync windows, both ends inclusive
    localparam int HSYNC_START_DEF = 280;
    localparam int HSYNC_END_DEF   = 319;
    localparam int VSYNC_START_DEF = 346;
    localparam int VSYNC_END_DEF   = 349;

    // Sound fetch owns memory for four cycles starting here; the word is latched on the last one
    localparam int SND_SLOT_DEF = 296;

    // Frame buffer word addresses (byte address >> 1)
    localparam word_addr_t VID_BASE_MAIN_DEF = 21'h1FD380;
    localparam word_addr_t VID_BASE_ALT_DEF  = 21'h1F9380;
    localparam word_addr_t SND_BASE_MAIN_DEF = 21'h1FFE80;
    localparam word_addr_t SND_BASE_ALT_DEF  = 21'h1FD080;

    typedef enum logic [1:0] {
        FETCH_NONE  = 2'd0,
        FETCH_VIDEO = 2'd1,
        FETCH_SOUND = 2'd2
    } fetch_kind_e;

    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - memory slot request and latch strobes from raster timing to the bus side
interface video_timing_if;
    import video_timing_pkg::*;

    logic       videoReq;
    word_addr_t videoAddr;
    logic       loadPixels;
    logic       loadSound;

    modport master (output videoReq, output videoAddr, output loadPixels, output loadSound);
    modport slave  (input  videoReq, input  videoAddr, input  loadPixels, input  loadSound);

endinterface

// File: rtl/video_counter.sv
// rtl/video_counter.sv - horizontal/vertical raster counters with last-position flags
module video_counter #(
    parameter int H_TOTAL = 352,
    parameter int V_TOTAL = 370,
    parameter int HW      = 9,
    parameter int VW      = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [HW-1:0] hcount_o,
    output logic [VW-1:0] vcount_o,
    output logic          h_wrap_o,
    output logic          v_wrap_o
);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          h_last, v_last;

    assign h_last = (int'(hcount_q) == H_TOTAL - 1);
    assign v_last = (int'(vcount_q) == V_TOTAL - 1);

    // Next count: hcount wraps every line, vcount steps only as hcount wraps
    always_comb begin
        hcount_d = h_last ? '0 : hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + VW'(1);
        end
    end

    // Counters advance only on the clk8 enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (en_i) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;
    assign h_wrap_o = h_last;
    assign v_wrap_o = v_last;

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing, blank/sync generation and video/sound memory fetch decode
module video_timing
    import video_timing_pkg::*;
#(
    parameter int         H_TOTAL       = H_TOTAL_DEF,
    parameter int         V_TOTAL       = V_TOTAL_DEF,
    parameter int         H_VISIBLE     = H_VISIBLE_DEF,
    parameter int         V_VISIBLE     = V_VISIBLE_DEF,
    parameter word_addr_t VID_BASE_MAIN = VID_BASE_MAIN_DEF,
    parameter word_addr_t VID_BASE_ALT  = VID_BASE_ALT_DEF,
    parameter word_addr_t SND_BASE_MAIN = SND_BASE_MAIN_DEF,
    parameter word_addr_t SND_BASE_ALT  = SND_BASE_ALT_DEF,
    parameter int         HSYNC_START   = HSYNC_START_DEF,
    parameter int         HSYNC_END     = HSYNC_END_DEF,
    parameter int         VSYNC_START   = VSYNC_START_DEF,
    parameter int         VSYNC_END     = VSYNC_END_DEF,
    parameter int         SND_SLOT      = SND_SLOT_DEF
) (
    input  logic          clk32,
    input  logic          _systemReset,
    input  logic          clk8_en_p,
    input  logic          vid_alt,
    input  logic          snd_alt,
    output logic          _hblank,
    output logic          _vblank,
    output logic          _hsync,
    output logic          _vsync,
    video_timing_if.master mem
);

    // hcount[7:3] selects the word within a line, so keep at least 8 bits
    localparam int HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int VW = ($clog2(V_TOTAL) < 1) ? 1 : $clog2(V_TOTAL);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          h_wrap, v_wrap;

    video_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_counter (
        .clk_i    (clk32),
        .rst_ni   (_systemReset),
        .en_i     (clk8_en_p),
        .hcount_o (hcount),
        .vcount_o (vcount),
        .h_wrap_o (h_wrap),
        .v_wrap_o (v_wrap)
    );

    logic        hblank_n_q, vblank_n_q, hsync_n_q, vsync_n_q;
    logic        load_pix_q, load_snd_q, req_q, frame_start_q;
    word_addr_t  addr_q, vid_base_q, snd_base_q;

    logic        hblank_n_d, vblank_n_d, hsync_n_d, vsync_n_d;
    logic        load_pix_d, load_snd_d, req_d;
    word_addr_t  addr_d, vid_base_d, snd_base_d;
    fetch_kind_e fetch;

    // Decode the current count; results are registered so every output lines up with the same count
    always_comb begin
        vid_base_d = vid_base_q;
        snd_base_d = snd_base_q;
        if (frame_start_q) begin
            vid_base_d = vid_alt ? VID_BASE_MAIN : VID_BASE_ALT;
            snd_base_d = snd_alt ? SND_BASE_ALT  : SND_BASE_MAIN;
        end

        hblank_n_d = (int'(hcount) < H_VISIBLE);
        vblank_n_d = (int'(vcount) < V_VISIBLE);
        hsync_n_d  = !in_range(int'(hcount), HSYNC_START, HSYNC_END);
        vsync_n_d  = !in_range(int'(vcount), VSYNC_START, VSYNC_END);

        fetch = FETCH_NONE;
        if (hblank_n_d && vblank_n_d && !hcount[2]) begin
            fetch = FETCH_VIDEO;
        end else if (in_range(int'(hcount), SND_SLOT, SND_SLOT + 3)) begin
            fetch = FETCH_SOUND;
        end

        addr_d     = addr_q;
        load_pix_d = 1'b0;
        load_snd_d = 1'b0;
        case (fetch)
            FETCH_VIDEO: begin
                addr_d     = vid_base_d + (word_addr_t'(vcount) << 5) + word_addr_t'(hcount[7:3]);
                load_pix_d = (hcount[1:0] == 2'b11);
            end
            FETCH_SOUND: begin
                addr_d     = snd_base_d + word_addr_t'(vcount);
                load_snd_d = (int'(hcount) == SND_SLOT + 3);
            end
            default: ;
        endcase
        req_d = (fetch != FETCH_NONE);
    end

    // Output and base-latch registers; reset forces the idle, unblanked-high values at once
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            hblank_n_q    <= 1'b1;
            vblank_n_q    <= 1'b1;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            load_pix_q    <= 1'b0;
            load_snd_q    <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            vid_base_q    <= VID_BASE_MAIN;
            snd_base_q    <= SND_BASE_MAIN;
            frame_start_q <= 1'b1;
        end else if (clk8_en_p) begin
            hblank_n_q    <= hblank_n_d;
            vblank_n_q    <= vblank_n_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            load_pix_q    <= load_pix_d;
            load_snd_q    <= load_snd_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            vid_base_q    <= vid_base_d;
            snd_base_q    <= snd_base_d;
            frame_start_q <= h_wrap && v_wrap;
        end
    end

    assign _hblank        = hblank_n_q;
    assign _vblank        = vblank_n_q;
    assign _hsync         = hsync_n_q;
    assign _vsync         = vsync_n_q;
    assign mem.videoReq   = req_q;
    assign mem.videoAddr  = addr_q;
    assign mem.loadPixels = load_pix_q;
    assign mem.loadSound  = load_snd_q;

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - randomized self-checking bench for video_timing, full-size and reduced raster
module tb_video_timing;

    typedef struct {
        int ht, vt, hv, vv, hs0, hs1, vs0, vs1, snd;
        logic [20:0] vmain, valt, smain, salt;
    } geom_t;

    logic clk32 = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic vid_alt = 1'b1;
    logic snd_alt = 1'b0;

    logic hb0, vb0, hs0, vs0, hb1, vb1, hs1, vs1;
    video_timing_if bus0 ();
    video_timing_if bus1 ();

    always #5 clk32 = ~clk32;

    video_timing u_big (
        .clk32 (clk32), ._systemReset (rst_n), .clk8_en_p (en),
        .vid_alt (vid_alt), .snd_alt (snd_alt),
        ._hblank (hb0), ._vblank (vb0), ._hsync (hs0), ._vsync (vs0),
        .mem (bus0)
    );

    video_timing #(
        .H_TOTAL (64), .V_TOTAL (24), .H_VISIBLE (32), .V_VISIBLE (16),
        .VID_BASE_MAIN (21'h1FFFC0), .VID_BASE_ALT (21'h000100),
        .SND_BASE_MAIN (21'h1FFFF8), .SND_BASE_ALT (21'h001000),
        .HSYNC_START (40), .HSYNC_END (47), .VSYNC_START (18), .VSYNC_END (19),
        .SND_SLOT (52)
    ) u_small (
        .clk32 (clk32), ._systemReset (rst_n), .clk8_en_p (en),
        .vid_alt (vid_alt), .snd_alt (snd_alt),
        ._hblank (hb1), ._vblank (vb1), ._hsync (hs1), ._vsync (vs1),
        .mem (bus1)
    );

    logic [27:0] obs [2];
    assign obs[0] = {hb0, vb0, hs0, vs0, bus0.loadPixels, bus0.loadSound, bus0.videoReq, bus0.videoAddr};
    assign obs[1] = {hb1, vb1, hs1, vs1, bus1.loadPixels, bus1.loadSound, bus1.videoReq, bus1.videoAddr};

    localparam logic [27:0] RESET_VEC = {4'b1111, 3'b000, 21'h0};

    int total = 0;
    int bad = 0;

    geom_t       g [2];
    int          m_pos [2];
    int          m_h [2];
    int          m_v [2];
    logic [20:0] m_vb [2];
    logic [20:0] m_sb [2];
    logic [20:0] m_addr [2];
    logic [27:0] m_exp [2];

    // Expected outputs for raster position (h, v), straight from the timing rules
    function automatic logic [27:0] model_out(input geom_t gg, input int h, input int v,
                                              input logic [20:0] vb, input logic [20:0] sb,
                                              input logic [20:0] prev_addr);
        logic vis, vslot, sslot;
        logic [20:0] addr;
        vis   = (h < gg.hv) && (v < gg.vv);
        vslot = vis && ((h % 8) < 4);
        sslot = (h >= gg.snd) && (h < gg.snd + 4);
        addr  = prev_addr;
        if (vslot)      addr = 21'(vb + v * 32 + h / 8);
        else if (sslot) addr = 21'(sb + v);
        return {h < gg.hv, v < gg.vv, !(h >= gg.hs0 && h <= gg.hs1), !(v >= gg.vs0 && v <= gg.vs1),
                vslot && ((h % 8) == 3), h == gg.snd + 3, vslot || sslot, addr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_h[i] = 0; m_v[i] = 0;
            m_vb[i] = g[i].vmain; m_sb[i] = g[i].smain;
            m_addr[i] = '0; m_exp[i] = RESET_VEC;
        end
    endtask

    task automatic step(input bit en_v);
        en = en_v;
        @(posedge clk32);
        if (en_v && rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = (m_pos[i] + 1) % (g[i].ht * g[i].vt);
                m_h[i] = m_pos[i] % g[i].ht;
                m_v[i] = m_pos[i] / g[i].ht;
                if (m_h[i] == 0 && m_v[i] == 0) begin
                    m_vb[i] = vid_alt ? g[i].vmain : g[i].valt;
                    m_sb[i] = snd_alt ? g[i].salt : g[i].smain;
                end
                m_exp[i] = model_out(g[i], m_h[i], m_v[i], m_vb[i], m_sb[i], m_addr[i]);
                m_addr[i] = m_exp[i][20:0];
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk32);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            vid_alt = 1'($urandom); snd_alt = 1'($urandom); en = 1'($urandom);
            @(posedge clk32); #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== RESET_VEC) begin
                    bad++; $display("FAIL reset_hold dut%0d got=%h exp=%h", i, obs[i], RESET_VEC);
                end
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== m_exp[i]) begin
                    bad++; $display("FAIL reset_idle dut%0d got=%h exp=%h", i, obs[i], m_exp[i]);
                end
            end
        end
    endtask

    task automatic test_first_line();
        int lp, ls;
        logic seen;
        logic [20:0] first_addr, last_pix, snd_addr;
        vid_alt = 1'b1; snd_alt = 1'b0;
        apply_reset();
        lp = 0; ls = 0; seen = 1'b0; first_addr = '0; last_pix = '0; snd_addr = '0;
        for (int k = 0; k < 361; k++) begin
            step(1'b1);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== m_exp[i]) begin
                    bad++; $display("FAIL first_line dut%0d pos=%0d got=%h exp=%h", i, m_pos[i], obs[i], m_exp[i]);
                end
            end
            if (k < 352) begin
                if (bus0.videoReq && !seen) begin first_addr = bus0.videoAddr; seen = 1'b1; end
                if (bus0.loadPixels) begin lp++; last_pix = bus0.videoAddr; end
                if (bus0.loadSound) begin ls++; snd_addr = bus0.videoAddr; end
            end
        end
        total++; if (lp !== 32) begin bad++; $display("FAIL line_loads got=%0d exp=32", lp); end
        total++; if (first_addr !== 21'h1FD380) begin bad++; $display("FAIL line_first_addr got=%h exp=1fd380", first_addr); end
        total++; if (last_pix !== 21'h1FD39F) begin bad++; $display("FAIL line_last_addr got=%h exp=1fd39f", last_pix); end
        total++; if (ls !== 1) begin bad++; $display("FAIL line_snd_loads got=%0d exp=1", ls); end
        total++; if (snd_addr !== 21'h1FFE80) begin bad++; $display("FAIL line_snd_addr got=%h exp=1ffe80", snd_addr); end
        total++;
        if (bus0.videoAddr !== 21'h1FD3A1 || bus0.videoReq !== 1'b1) begin
            bad++; $display("FAIL v1h8_addr got=%h req=%b exp=1fd3a1 req=1", bus0.videoAddr, bus0.videoReq);
        end
    endtask

    task automatic test_gating();
        apply_reset();
        for (int k = 0; k < 11; k++) step(1'b1);
        for (int k = 0; k < 150; k++) begin
            step(k >= 50);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== m_exp[i]) begin
                    bad++; $display("FAIL gating dut%0d cyc=%0d got=%h exp=%h", i, k, obs[i], m_exp[i]);
                end
            end
        end
    endtask

    task automatic test_random_run();
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 299) == 0) vid_alt = ~vid_alt;
            if ($urandom_range(0, 299) == 0) snd_alt = ~snd_alt;
            step(($urandom % 4) != 0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== m_exp[i]) begin
                    bad++; $display("FAIL random dut%0d pos=%0d got=%h exp=%h", i, m_pos[i], obs[i], m_exp[i]);
                end
            end
        end
    endtask

    task automatic test_small_frame();
        int lp, ls, vbl, vsl, lp_blank;
        vid_alt = 1'b1; snd_alt = 1'b0;
        apply_reset();
        lp = 0; ls = 0; vbl = 0; vsl = 0; lp_blank = 0;
        for (int k = 0; k < 2 * 1536; k++) begin
            step(1'b1);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== m_exp[i]) begin
                    bad++; $display("FAIL frame dut%0d pos=%0d got=%h exp=%h", i, m_pos[i], obs[i], m_exp[i]);
                end
            end
            if (k < 1536) begin
                lp += int'(bus1.loadPixels); ls += int'(bus1.loadSound);
                vbl += int'(!vb1); vsl += int'(!vs1);
                if (bus1.loadPixels && m_v[1] >= 16) lp_blank++;
                if (m_v[1] == 10 && m_h[1] == 0) begin vid_alt = 1'b0; snd_alt = 1'b1; end
                if (m_v[1] == 12 && m_h[1] == 0) begin
                    total++;
                    if (bus1.videoAddr !== 21'h000140) begin bad++; $display("FAIL wrap_vid_addr got=%h exp=000140", bus1.videoAddr); end
                end
                if (m_v[1] == 23 && m_h[1] == 55) begin
                    total++;
                    if (bus1.videoAddr !== 21'h00000F) begin bad++; $display("FAIL wrap_snd_addr got=%h exp=00000f", bus1.videoAddr); end
                end
            end else if (m_v[1] == 0 && m_h[1] == 0) begin
                total++;
                if (bus1.videoAddr !== 21'h000100) begin bad++; $display("FAIL alt_vid_base got=%h exp=000100", bus1.videoAddr); end
            end else if (m_v[1] == 0 && m_h[1] == 55) begin
                total++;
                if (bus1.videoAddr !== 21'h001000 || bus1.loadSound !== 1'b1) begin
                    bad++; $display("FAIL alt_snd_base got=%h ls=%b exp=001000 ls=1", bus1.videoAddr, bus1.loadSound);
                end
            end
        end
        total++; if (lp !== 64) begin bad++; $display("FAIL frame_pix_loads got=%0d exp=64", lp); end
        total++; if (ls !== 24) begin bad++; $display("FAIL frame_snd_loads got=%0d exp=24", ls); end
        total++; if (vbl !== 8 * 64) begin bad++; $display("FAIL frame_vblank got=%0d exp=%0d", vbl, 8 * 64); end
        total++; if (vsl !== 2 * 64) begin bad++; $display("FAIL frame_vsync got=%0d exp=%0d", vsl, 2 * 64); end
        total++; if (lp_blank !== 0) begin bad++; $display("FAIL blank_line_loads got=%0d exp=0", lp_blank); end
    endtask

    task automatic test_reset_abort();
        vid_alt = 1'b1; snd_alt = 1'b0;
        apply_reset();
        for (int k = 0; k < 299; k++) step(1'b1);
        total++;
        if (obs[0] !== m_exp[0]) begin bad++; $display("FAIL pre_abort got=%h exp=%h", obs[0], m_exp[0]); end
        en = 1'b1;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== RESET_VEC) begin bad++; $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs[i], RESET_VEC); end
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            total++;
            if (bus0.loadSound !== 1'b0 || obs[0] !== RESET_VEC) begin
                bad++; $display("FAIL abort_strobe got=%h exp=%h", obs[0], RESET_VEC);
            end
        end
        rst_n = 1'b1;
        step(1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== m_exp[i]) begin bad++; $display("FAIL restart dut%0d got=%h exp=%h", i, obs[i], m_exp[i]); end
        end
    endtask

    initial begin
        g[0] = '{352, 370, 256, 342, 280, 319, 346, 349, 296,
                 21'h1FD380, 21'h1F9380, 21'h1FFE80, 21'h1FD080};
        g[1] = '{64, 24, 32, 16, 40, 47, 18, 19, 52,
                 21'h1FFFC0, 21'h000100, 21'h1FFFF8, 21'h001000};
        model_reset();
        test_reset();
        test_first_line();
        test_gating();
        test_random_run();
        test_small_frame();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
